// File: rtl/sha3_scan_dispatcher_if.sv
// Handshake and data bundle between the scan dispatcher, the host-side job
// source/result sink, and the sha3 scanner instantiator.
// slave  : the dispatcher's view.
// master : the view of the logic surrounding the dispatcher (host + scanner).
interface sha3_scan_dispatcher_if #(
    parameter int INPUT_ELEMENTS = 20
);
    // Job channel
    logic                             job_valid;
    logic                             job_ready;
    logic [INPUT_ELEMENTS-1:0][31:0]  job_blobby;
    logic [63:0]                      job_threshold;
    logic [31:0]                      job_nonce_base;
    logic [15:0]                      job_runs;
    logic                             abort;
    // Scanner channel
    logic                             scan_start;
    logic [INPUT_ELEMENTS-1:0][31:0]  scan_blobby;
    logic [63:0]                      scan_threshold;
    logic                             scan_idle;
    logic                             scan_found;
    logic [24:0][63:0]                scan_hash;
    logic [31:0]                      scan_nonce;
    logic [31:0]                      scan_count;
    logic                             scan_evaluating;
    // Result channel
    logic                             res_valid;
    logic                             res_ready;
    logic [1:0]                       res_status;
    logic [31:0]                      res_nonce;
    logic [24:0][63:0]                res_hash;
    logic [15:0]                      res_runs;
    logic [47:0]                      stat_hashes;

    modport slave (
        input  job_valid, job_blobby, job_threshold, job_nonce_base, job_runs, abort,
        input  scan_idle, scan_found, scan_hash, scan_nonce, scan_count, scan_evaluating,
        input  res_ready,
        output job_ready, scan_start, scan_blobby, scan_threshold,
        output res_valid, res_status, res_nonce, res_hash, res_runs, stat_hashes
    );

    modport master (
        output job_valid, job_blobby, job_threshold, job_nonce_base, job_runs, abort,
        output scan_idle, scan_found, scan_hash, scan_nonce, scan_count, scan_evaluating,
        output res_ready,
        input  job_ready, scan_start, scan_blobby, scan_threshold,
        input  res_valid, res_status, res_nonce, res_hash, res_runs, stat_hashes
    );
endinterface

// File: rtl/sha3_scan_dispatcher.sv
// Job-level sequencer in front of the sha3 scanner instantiator.
// Takes one mining job, relaunches the scanner with an advancing nonce base,
// and reports a single FOUND / EXHAUSTED / ABORTED / WRAPPED record.
// Optional feature macro: SHA3_DISPATCH_STATS_EN (evaluating-cycle counter on
// stat_hashes; tied to zero when undefined).
module sha3_scan_dispatcher #(
    parameter int INPUT_ELEMENTS = 20,
    parameter int NONCE_WORD     = 19
) (
    input  logic                   clk,
    input  logic                   rst,
    sha3_scan_dispatcher_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_REPORT
    } state_t;

    typedef enum logic [1:0] {
        ST_FOUND     = 2'd0,
        ST_EXHAUSTED = 2'd1,
        ST_ABORTED   = 2'd2,
        ST_WRAPPED   = 2'd3
    } status_t;

    state_t                           r_state;
    logic                             r_scan_start;
    logic [INPUT_ELEMENTS-1:0][31:0]  r_scan_blobby;
    logic [63:0]                      r_scan_threshold;
    logic [31:0]                      r_cur_base;
    logic [15:0]                      r_runs_left;
    logic [15:0]                      r_runs_done;
    logic                             r_abort_pending;
    logic                             r_res_valid;
    status_t                          r_res_status;
    logic [31:0]                      r_res_nonce;
    logic [24:0][63:0]                r_res_hash;
    logic [15:0]                      r_res_runs;

    logic [32:0]                      w_sum;
    logic                             w_abort;

    assign w_sum   = {1'b0, r_cur_base} + {1'b0, bus.scan_count};
    assign w_abort = r_abort_pending | bus.abort;

    assign bus.job_ready      = (r_state == S_IDLE) & ~rst;
    assign bus.scan_start     = r_scan_start;
    assign bus.scan_blobby    = r_scan_blobby;
    assign bus.scan_threshold = r_scan_threshold;
    assign bus.res_valid      = r_res_valid;
    assign bus.res_status     = r_res_status;
    assign bus.res_nonce      = r_res_nonce;
    assign bus.res_hash       = r_res_hash;
    assign bus.res_runs       = r_res_runs;

    // Job FSM: the start strobe is raised on the transition into LAUNCH so it
    // appears one cycle after accept / scanner completion; LAUNCH then either
    // retires the strobe or retries once the scanner reports idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_scan_start     <= 1'b0;
            r_scan_blobby    <= '0;
            r_scan_threshold <= '0;
            r_cur_base       <= '0;
            r_runs_left      <= '0;
            r_runs_done      <= '0;
            r_abort_pending  <= 1'b0;
            r_res_valid      <= 1'b0;
            r_res_status     <= ST_FOUND;
            r_res_nonce      <= '0;
            r_res_hash       <= '0;
            r_res_runs       <= '0;
        end else begin
            r_scan_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.job_valid) begin
                        r_scan_blobby             <= bus.job_blobby;
                        r_scan_blobby[NONCE_WORD] <= bus.job_nonce_base;
                        r_scan_threshold          <= bus.job_threshold;
                        r_cur_base                <= bus.job_nonce_base;
                        r_runs_left               <= bus.job_runs;
                        r_runs_done               <= '0;
                        r_abort_pending           <= 1'b0;
                        if (bus.job_runs == '0) begin
                            r_state      <= S_REPORT;
                            r_res_valid  <= 1'b1;
                            r_res_status <= ST_EXHAUSTED;
                            r_res_nonce  <= bus.job_nonce_base;
                            r_res_hash   <= '0;
                            r_res_runs   <= '0;
                        end else begin
                            r_state      <= S_LAUNCH;
                            r_scan_start <= bus.scan_idle;
                        end
                    end
                end
                S_LAUNCH: begin
                    if (r_scan_start) begin
                        r_abort_pending <= w_abort;
                        r_state         <= S_WAIT_ACK;
                    end else if (w_abort) begin
                        r_state      <= S_REPORT;
                        r_res_valid  <= 1'b1;
                        r_res_status <= ST_ABORTED;
                        r_res_nonce  <= r_cur_base;
                        r_res_hash   <= '0;
                        r_res_runs   <= r_runs_done;
                    end else if (bus.scan_idle) begin
                        r_scan_start <= 1'b1;
                    end
                end
                S_WAIT_ACK: begin
                    r_abort_pending <= w_abort;
                    if (!bus.scan_idle) begin
                        r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!bus.scan_idle) begin
                        r_abort_pending <= w_abort;
                    end else begin
                        r_runs_done <= r_runs_done + 16'd1;
                        r_runs_left <= r_runs_left - 16'd1;
                        r_res_runs  <= r_runs_done + 16'd1;
                        r_res_nonce <= w_sum[31:0];
                        r_res_hash  <= '0;
                        if (bus.scan_found) begin
                            r_state      <= S_REPORT;
                            r_res_valid  <= 1'b1;
                            r_res_status <= ST_FOUND;
                            r_res_nonce  <= bus.scan_nonce;
                            r_res_hash   <= bus.scan_hash;
                        end else if (w_abort) begin
                            r_state      <= S_REPORT;
                            r_res_valid  <= 1'b1;
                            r_res_status <= ST_ABORTED;
                        end else if (w_sum[32]) begin
                            r_state      <= S_REPORT;
                            r_res_valid  <= 1'b1;
                            r_res_status <= ST_WRAPPED;
                        end else if (r_runs_left == 16'd1) begin
                            r_state      <= S_REPORT;
                            r_res_valid  <= 1'b1;
                            r_res_status <= ST_EXHAUSTED;
                        end else begin
                            r_cur_base                <= w_sum[31:0];
                            r_scan_blobby[NONCE_WORD] <= w_sum[31:0];
                            r_scan_start              <= 1'b1;
                            r_state                   <= S_LAUNCH;
                        end
                    end
                end
                S_REPORT: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef SHA3_DISPATCH_STATS_EN
    logic [47:0] r_stat_hashes;

    // Saturating count of scanner evaluating cycles within the current job.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_hashes <= '0;
        end else if (r_state == S_IDLE && bus.job_valid) begin
            r_stat_hashes <= '0;
        end else if ((r_state == S_WAIT_ACK || r_state == S_WAIT_DONE) &&
                     bus.scan_evaluating && r_stat_hashes != '1) begin
            r_stat_hashes <= r_stat_hashes + 48'd1;
        end
    end

    assign bus.stat_hashes = r_stat_hashes;
`else
    assign bus.stat_hashes = '0;
`endif

endmodule

// File: tb/tb_sha3_scan_dispatcher.sv
// Directed testbench for sha3_scan_dispatcher with a behavioural scanner:
// scan_count = 256, 7 evaluating cycles per run, optional find on a chosen run.
module tb_sha3_scan_dispatcher;

    localparam int IE = 20;
    localparam int NW = 19;
`ifdef SHA3_DISPATCH_STATS_EN
    localparam int STATS_ON = 1;
`else
    localparam int STATS_ON = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sha3_scan_dispatcher_if #(.INPUT_ELEMENTS(IE)) bus ();

    sha3_scan_dispatcher #(.INPUT_ELEMENTS(IE), .NONCE_WORD(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Scanner model state
    logic              m_idle;
    logic              m_eval;
    logic              m_found;
    int                m_cnt;
    int unsigned       m_cur_run;
    int unsigned       m_strobes   = 0;
    int unsigned       m_bad_words = 0;
    logic [31:0]       strobe_base [64];
    // Job-context set by the stimulus process only
    int unsigned       tb_job_start = 0;
    int unsigned       tb_find_run  = 0;
    logic [31:0]       tb_find_nonce = 32'h5555_5555;
    logic [24:0][63:0] tb_hash;

    assign bus.scan_idle       = m_idle;
    assign bus.scan_found      = m_found;
    assign bus.scan_nonce      = tb_find_nonce;
    assign bus.scan_hash       = tb_hash;
    assign bus.scan_count      = 32'd256;
    assign bus.scan_evaluating = m_eval;

    // Behavioural scanner: capture on start, 7 evaluating cycles, then idle.
    always @(posedge clk) begin
        if (rst) begin
            m_idle  <= 1'b1;
            m_eval  <= 1'b0;
            m_found <= 1'b0;
            m_cnt   <= 0;
        end else if (m_idle && bus.scan_start) begin
            int unsigned nb;
            nb = 0;
            for (int i = 0; i < IE; i++)
                if (i != NW && bus.scan_blobby[i] !== bus.job_blobby[i]) nb++;
            m_bad_words <= m_bad_words + nb;
            strobe_base[m_strobes % 64] <= bus.scan_blobby[NW];
            m_cur_run <= m_strobes - tb_job_start + 1;
            m_strobes <= m_strobes + 1;
            m_idle  <= 1'b0;
            m_eval  <= 1'b1;
            m_found <= 1'b0;
            m_cnt   <= 6;
        end else if (!m_idle) begin
            if (m_cnt == 0) begin
                m_idle  <= 1'b1;
                m_eval  <= 1'b0;
                m_found <= (m_cur_run == tb_find_run);
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    task automatic set_job(input logic [31:0] base, input logic [15:0] runs,
                           input int unsigned find_run, input logic [31:0] find_nonce);
        for (int i = 0; i < IE; i++) bus.job_blobby[i] = 32'hA000_0000 + i * 32'h0101;
        bus.job_blobby[NW] = 32'hFFFF_FFFF;
        bus.job_threshold  = {base, ~base};
        bus.job_nonce_base = base;
        bus.job_runs       = runs;
        tb_find_run        = find_run;
        tb_find_nonce      = find_nonce;
        tb_hash            = '0;
        tb_hash[0]         = 64'hDEAD;
        tb_hash[24]        = 64'hBEEF;
    endtask

    task automatic send_job();
        @(negedge clk);
        tb_job_start  = m_strobes;
        bus.job_valid = 1'b1;
        @(posedge clk);
        #1 bus.job_valid = 1'b0;
    endtask

    task automatic wait_res(input int max_cycles, output bit got);
        got = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (bus.res_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic ack();
        @(negedge clk);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1 bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests_run++;
        if (bus.job_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_job_ready_low: got %b want 0", bus.job_ready); end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.job_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.scan_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: ready=%b res_valid=%b start=%b want 1 0 0", bus.job_ready, bus.res_valid, bus.scan_start);
        end
        tests_run++;
        if (bus.res_status !== 2'd0 || bus.res_nonce !== 32'd0 || bus.res_runs !== 16'd0 || bus.stat_hashes !== 48'd0) begin
            tests_failed++;
            $display("FAIL reset_fields: status=%0d nonce=%h runs=%0d stat=%0d want zeros", bus.res_status, bus.res_nonce, bus.res_runs, bus.stat_hashes);
        end
        tests_run++;
        if (bus.scan_blobby !== '0 || bus.scan_threshold !== 64'd0 || bus.res_hash !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: scan_blobby/threshold/res_hash nonzero, want 0");
        end
    endtask

    task automatic test_exhausted();
        bit got;
        int unsigned s0;
        s0 = m_strobes;
        set_job(32'h100, 16'd3, 0, 32'h0);
        send_job();
        @(negedge clk);
        tests_run++;
        if (bus.scan_start !== 1'b1) begin tests_failed++; $display("FAIL accept_to_start: got %b want 1", bus.scan_start); end
        wait_res(200, got);
        tests_run++;
        if (!got) begin tests_failed++; $display("FAIL exh_timeout: res_valid=0 want 1"); end
        tests_run++;
        if (bus.res_status !== 2'd1 || bus.res_nonce !== 32'h400 || bus.res_runs !== 16'd3 || bus.res_hash !== '0) begin
            tests_failed++;
            $display("FAIL exh_result: status=%0d nonce=%h runs=%0d want 1 00000400 3 (hash 0)", bus.res_status, bus.res_nonce, bus.res_runs);
        end
        tests_run++;
        if (m_strobes - s0 != 3) begin tests_failed++; $display("FAIL exh_strobes: got %0d want 3", m_strobes - s0); end
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (strobe_base[(s0 + k) % 64] !== 32'h100 * (k + 1)) begin
                tests_failed++;
                $display("FAIL exh_nonce_word%0d: got %h want %h", k, strobe_base[(s0 + k) % 64], 32'h100 * (k + 1));
            end
        end
        tests_run++;
        if (m_bad_words != 0 || bus.scan_threshold !== 64'h0000_0100_FFFF_FEFF) begin
            tests_failed++;
            $display("FAIL exh_scan_data: bad_words=%0d thr=%h want 0 00000100fffffeff", m_bad_words, bus.scan_threshold);
        end
        tests_run++;
        if (bus.stat_hashes !== 48'(STATS_ON * 21)) begin tests_failed++; $display("FAIL exh_stats: got %0d want %0d", bus.stat_hashes, STATS_ON * 21); end
        ack();
    endtask

    task automatic test_found();
        bit got;
        int unsigned s0;
        s0 = m_strobes;
        set_job(32'h200, 16'd5, 2, 32'h2A5);
        send_job();
        wait_res(200, got);
        tests_run++;
        if (!got) begin tests_failed++; $display("FAIL found_timeout: res_valid=0 want 1"); end
        tests_run++;
        if (bus.res_status !== 2'd0 || bus.res_nonce !== 32'h2A5 || bus.res_runs !== 16'd2) begin
            tests_failed++;
            $display("FAIL found_result: status=%0d nonce=%h runs=%0d want 0 000002a5 2", bus.res_status, bus.res_nonce, bus.res_runs);
        end
        tests_run++;
        if (bus.res_hash[0] !== 64'hDEAD || bus.res_hash[24] !== 64'hBEEF) begin
            tests_failed++;
            $display("FAIL found_hash: w0=%h w24=%h want dead beef", bus.res_hash[0], bus.res_hash[24]);
        end
        tests_run++;
        if (m_strobes - s0 != 2) begin tests_failed++; $display("FAIL found_strobes: got %0d want 2", m_strobes - s0); end
        ack();
    endtask

    task automatic test_back_to_back();
        bit got;
        @(negedge clk);
        tests_run++;
        if (bus.job_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_idle: ready=%b res_valid=%b want 1 0", bus.job_ready, bus.res_valid);
        end
        bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
        set_job(32'h10, 16'd1, 0, 32'h0);
        send_job();
        wait_res(100, got);
        tests_run++;
        if (!got || bus.res_status !== 2'd1 || bus.res_nonce !== 32'h110 || bus.res_runs !== 16'd1) begin
            tests_failed++;
            $display("FAIL idle_abort_ignored: got=%b status=%0d nonce=%h runs=%0d want 1 1 00000110 1", got, bus.res_status, bus.res_nonce, bus.res_runs);
        end
        ack();
    endtask

    task automatic test_wrap();
        bit got;
        int unsigned s0;
        s0 = m_strobes;
        set_job(32'hFFFF_FF00, 16'd5, 0, 32'h0);
        send_job();
        wait_res(200, got);
        tests_run++;
        if (!got || bus.res_status !== 2'd3 || bus.res_nonce !== 32'd0 || bus.res_runs !== 16'd1) begin
            tests_failed++;
            $display("FAIL wrap_result: got=%b status=%0d nonce=%h runs=%0d want 1 3 00000000 1", got, bus.res_status, bus.res_nonce, bus.res_runs);
        end
        tests_run++;
        if (m_strobes - s0 != 1 || bus.stat_hashes !== 48'(STATS_ON * 7)) begin
            tests_failed++;
            $display("FAIL wrap_strobes_stats: strobes=%0d stat=%0d want 1 %0d", m_strobes - s0, bus.stat_hashes, STATS_ON * 7);
        end
        ack();
    endtask

    task automatic test_abort(input int unsigned find_run);
        bit got;
        int unsigned s0;
        s0 = m_strobes;
        set_job(32'h1000, 16'd10, find_run, 32'h1042);
        send_job();
        repeat (3) @(posedge clk);
        #1 bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
        wait_res(200, got);
        tests_run++;
        if (!got || m_strobes - s0 != 1 || bus.res_runs !== 16'd1) begin
            tests_failed++;
            $display("FAIL abort_runs_f%0d: got=%b strobes=%0d runs=%0d want 1 1 1", find_run, got, m_strobes - s0, bus.res_runs);
        end
        tests_run++;
        if (find_run == 0) begin
            if (bus.res_status !== 2'd2 || bus.res_nonce !== 32'h1100) begin
                tests_failed++;
                $display("FAIL abort_result: status=%0d nonce=%h want 2 00001100", bus.res_status, bus.res_nonce);
            end
        end else begin
            if (bus.res_status !== 2'd0 || bus.res_nonce !== 32'h1042) begin
                tests_failed++;
                $display("FAIL abort_found_wins: status=%0d nonce=%h want 0 00001042", bus.res_status, bus.res_nonce);
            end
        end
        ack();
    endtask

    task automatic test_hold();
        bit got;
        bit bad;
        set_job(32'h50, 16'd1, 0, 32'h0);
        send_job();
        wait_res(100, got);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.res_valid !== 1'b1 || bus.job_ready !== 1'b0 || bus.res_status !== 2'd1 ||
                bus.res_nonce !== 32'h150 || bus.res_runs !== 16'd1) bad = 1'b1;
        end
        tests_run++;
        if (!got || bad) begin
            tests_failed++;
            $display("FAIL hold_stable: got=%b unstable=%b valid=%b ready=%b nonce=%h want 1 0 1 0 00000150", got, bad, bus.res_valid, bus.job_ready, bus.res_nonce);
        end
        ack();
    endtask

    task automatic test_zero_runs();
        int unsigned s0;
        s0 = m_strobes;
        set_job(32'h777, 16'd0, 0, 32'h0);
        send_job();
        @(negedge clk);
        tests_run++;
        if (bus.res_valid !== 1'b1 || bus.scan_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_latency: res_valid=%b start=%b want 1 0", bus.res_valid, bus.scan_start);
        end
        tests_run++;
        if (bus.res_status !== 2'd1 || bus.res_nonce !== 32'h777 || bus.res_runs !== 16'd0 || m_strobes != s0) begin
            tests_failed++;
            $display("FAIL zero_result: status=%0d nonce=%h runs=%0d strobes=%0d want 1 00000777 0 0", bus.res_status, bus.res_nonce, bus.res_runs, m_strobes - s0);
        end
        ack();
    endtask

    task automatic test_rst_mid_job();
        bit seen;
        int unsigned s1;
        set_job(32'h2000, 16'd3, 0, 32'h0);
        send_job();
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.job_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.scan_start !== 1'b0 ||
            bus.res_status !== 2'd0 || bus.res_nonce !== 32'd0 || bus.res_runs !== 16'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_ctrl: ready=%b valid=%b start=%b status=%0d nonce=%h runs=%0d want 1 0 0 0 0 0",
                     bus.job_ready, bus.res_valid, bus.scan_start, bus.res_status, bus.res_nonce, bus.res_runs);
        end
        tests_run++;
        if (bus.scan_blobby !== '0 || bus.scan_threshold !== 64'd0 || bus.stat_hashes !== 48'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_data: thr=%h stat=%0d (blobby nonzero?) want 0 0", bus.scan_threshold, bus.stat_hashes);
        end
        s1 = m_strobes;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.res_valid === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (seen || m_strobes != s1) begin
            tests_failed++;
            $display("FAIL rst_mid_quiet: res_seen=%b new_strobes=%0d want 0 0", seen, m_strobes - s1);
        end
    endtask

    initial begin
        bus.job_valid = 1'b0;
        bus.res_ready = 1'b0;
        bus.abort     = 1'b0;
        set_job(32'h0, 16'd0, 0, 32'h0);
        repeat (3) @(posedge clk);
        test_reset();
        test_exhausted();
        test_found();
        test_back_to_back();
        test_wrap();
        test_abort(0);
        test_abort(1);
        test_hold();
        test_zero_runs();
        test_rst_mid_job();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global time bound so a stuck handshake cannot hang the run.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule
